aud_mode_ctrl: RTL and testbench
================================

// Module: aud_mode_ctrl
// PURPOSE
//  Central sequencer for the WM8731 record/playback datapath. Triggers I2C codec init,
//  converts key presses into one-cycle start/pause/stop strobes for recorder and DSP/player,
//  latches speed/interp settings, records end-of-recording address, grants SRAM ownership.
//  Sits in the top level between the keys/switches and the recorder, DSP, player and SRAM muxes.
// PARAMETERS
//  ADDR_W    20            SRAM word-address width
//  MAX_ADDR  2**ADDR_W-1   last writable address; reaching it auto-stops recording
//  SPD_W     3             speed-factor width (factor = value+1, 1x..8x)
// PORTS
//  i_clk          in   1       system clock (AUD_BCLK domain); all logic on posedge
//  i_rst          in   1       asynchronous reset, active-high
//  i_key_0        in   1       record / record-pause key, synchronous level, 1 = pressed
//  i_key_1        in   1       play / play-pause key, synchronous level, 1 = pressed
//  i_key_2        in   1       stop key, synchronous level, 1 = pressed
//  i_speed_sw     in   SPD_W+1 [SPD_W]=1 fast, 0 slow; [SPD_W-1:0] factor-1
//  i_interp_sw    in   1       slow mode: 0 constant, 1 linear interpolation
//  i_init_done    in   1       I2C initializer finished (level)
//  i_rec_addr     in   ADDR_W  recorder current write address
//  i_play_addr    in   ADDR_W  DSP current read address
//  o_i2c_start    out  1       1-cycle init strobe
//  o_rec_start/o_rec_pause/o_rec_stop     out 1 each  1-cycle recorder strobes
//  o_play_start/o_play_pause/o_play_stop  out 1 each  1-cycle DSP/player strobes
//  o_fast, o_slow_0, o_slow_1  out 1 each  playback mode levels (one-hot or all 0 = 1x)
//  o_speed        out  SPD_W   latched factor-1
//  o_sram_rec_sel out  1       1 = recorder owns SRAM (write), 0 = player reads
//  o_rec_end_addr out  ADDR_W  last address of valid recording
//  o_state        out  3       current state encoding (debug/LED)
// BEHAVIOUR
//  - Reset: state S_INIT, all strobes 0, mode levels 0, o_speed 0, o_sram_rec_sel 0,
//    o_rec_end_addr 0. Reset mid-operation aborts everything; no stop strobes emitted.
//  - Press = key high this cycle, low previous cycle (1 edge register per key, reset 0).
//  - All outputs registered: press at edge n -> new state + strobe valid after edge n+1, 1 cycle wide.
//  - Simultaneous presses: key_2 > key_0 > key_1; only the winner acts, others are dropped.
//  - States: S_INIT=0 S_IDLE=1 S_REC=2 S_REC_PAUSE=3 S_PLAY=4 S_PLAY_PAUSE=5.
//  - S_INIT: o_i2c_start pulses on first clock after reset release; i_init_done=1 -> S_IDLE.
//    Keys ignored. i_init_done ignored in all other states.
//  - S_IDLE: key_0 -> S_REC, o_rec_start. key_1 -> S_PLAY, o_play_start, only if
//    o_rec_end_addr != 0 (else ignored). key_2 ignored.
//  - S_REC: key_0 -> S_REC_PAUSE, o_rec_pause. key_2 -> S_IDLE, o_rec_stop,
//    o_rec_end_addr <= i_rec_addr. i_rec_addr == MAX_ADDR -> same as key_2 (auto-stop
//    overrides keys in that cycle).
//  - S_REC_PAUSE: key_0 -> S_REC, o_rec_start (resume). key_2 -> stop as in S_REC.
//  - S_PLAY: key_1 -> S_PLAY_PAUSE, o_play_pause. key_2 -> S_IDLE, o_play_stop.
//    i_play_addr >= o_rec_end_addr -> S_IDLE, o_play_stop (overrides keys).
//  - S_PLAY_PAUSE: key_1 -> S_PLAY, o_play_start. key_2 -> S_IDLE, o_play_stop.
//  - Speed latch on every transition into S_PLAY: o_speed <= i_speed_sw[SPD_W-1:0];
//    factor 0 -> all mode levels 0; else [SPD_W]=1 -> o_fast; else i_interp_sw picks
//    o_slow_1 (1) / o_slow_0 (0). Levels held in S_PLAY_PAUSE, cleared to 0 in S_IDLE.
//    Switch changes while playing have no effect until next entry into S_PLAY.
//  - o_sram_rec_sel = 1 in S_REC and S_REC_PAUSE, 0 otherwise (registered with state).
//  - Recording from S_IDLE restarts at address 0; o_rec_end_addr keeps its old value
//    until the stop, so a stale recording remains playable only after the new stop.
// TESTING
//  1 Reset release, i_init_done=1 after 10 cycles -> o_i2c_start 1 cycle at cycle 1; S_IDLE at cycle 11.
//  2 IDLE, key_1 press with end_addr=0 -> no strobe, stays IDLE; key_0 press -> o_rec_start 1 cycle, S_REC, sel=1.
//  3 REC, i_rec_addr=0x00123, key_2 -> o_rec_stop, S_IDLE, o_rec_end_addr=0x00123; i_rec_addr=MAX_ADDR -> auto-stop.
//  4 IDLE, i_speed_sw=4'b1011 -> play: o_fast=1, o_speed=3; i_speed_sw=4'b0001,i_interp_sw=1 -> o_slow_1=1.
//  5 PLAY, i_play_addr reaches o_rec_end_addr -> o_play_stop 1 cycle, S_IDLE, mode levels 0.
//  6 PLAY, key_1 and key_2 same cycle -> key_2 wins, o_play_stop only; reset asserted in S_REC -> S_INIT, no strobes.

Source files
------------

// File: rtl/aud_mode_ctrl.sv
// ----------------------------------------------------------------------------
// aud_mode_ctrl
//   Central sequencer for the WM8731 record/playback datapath. Kicks off the
//   I2C codec initialiser, turns key presses into one-cycle start/pause/stop
//   strobes for the recorder and the DSP/player, latches the playback speed
//   and interpolation mode, remembers where the last recording ended and
//   decides which side owns the SRAM.
//
// Ports
//   i_clk, i_rst                 clock (posedge), async active-high reset
//   i_key_0 / i_key_1 / i_key_2  record/pause, play/pause, stop key levels
//   i_speed_sw                   [SPD_W] fast(1)/slow(0), [SPD_W-1:0] factor-1
//   i_interp_sw                  slow mode: 0 constant, 1 linear interpolation
//   i_init_done                  I2C initialiser finished (level)
//   i_rec_addr, i_play_addr      recorder write / DSP read word addresses
//   o_i2c_start                  one-cycle codec init strobe
//   o_rec_*, o_play_*            one-cycle recorder / player strobes
//   o_fast, o_slow_0, o_slow_1   playback mode levels (one-hot, all 0 = 1x)
//   o_speed                      latched factor-1
//   o_sram_rec_sel               1 = recorder owns SRAM, 0 = player reads
//   o_rec_end_addr               last address of the valid recording
//   o_state                      current state encoding (debug/LED)
// ----------------------------------------------------------------------------
module aud_mode_ctrl #(
    parameter int unsigned       ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
    parameter int unsigned       SPD_W    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_0,
    input  logic              i_key_1,
    input  logic              i_key_2,
    input  logic [SPD_W:0]    i_speed_sw,
    input  logic              i_interp_sw,
    input  logic              i_init_done,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_i2c_start,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic              o_fast,
    output logic              o_slow_0,
    output logic              o_slow_1,
    output logic [SPD_W-1:0]  o_speed,
    output logic              o_sram_rec_sel,
    output logic [ADDR_W-1:0] o_rec_end_addr,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_REC        = 3'd2,
        S_REC_PAUSE  = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t            state_q,      state_d;
    logic [2:0]        key_prev_q,   key_prev_d;
    logic              init_sent_q,  init_sent_d;
    logic              i2c_start_q,  i2c_start_d;
    logic              rec_start_q,  rec_start_d;
    logic              rec_pause_q,  rec_pause_d;
    logic              rec_stop_q,   rec_stop_d;
    logic              play_start_q, play_start_d;
    logic              play_pause_q, play_pause_d;
    logic              play_stop_q,  play_stop_d;
    logic              fast_q,       fast_d;
    logic              slow_0_q,     slow_0_d;
    logic              slow_1_q,     slow_1_d;
    logic [SPD_W-1:0]  speed_q,      speed_d;
    logic              sel_q,        sel_d;
    logic [ADDR_W-1:0] end_addr_q,   end_addr_d;

    logic [2:0] keys;
    logic [2:0] press;
    logic       win_0, win_1, win_2;
    logic       enter_play;

    assign keys  = {i_key_2, i_key_1, i_key_0};
    assign press = keys & ~key_prev_q;

    // Only the highest-priority press acts (stop > record > play); the
    // losers are dropped even when the winner means nothing in this state.
    assign win_2 = press[2];
    assign win_0 = press[0] & ~press[2];
    assign win_1 = press[1] & ~press[2] & ~press[0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned -- that is what keeps this block latch-free.
        state_d      = state_q;
        key_prev_d   = keys;
        init_sent_d  = init_sent_q;
        i2c_start_d  = 1'b0;
        rec_start_d  = 1'b0;
        rec_pause_d  = 1'b0;
        rec_stop_d   = 1'b0;
        play_start_d = 1'b0;
        play_pause_d = 1'b0;
        play_stop_d  = 1'b0;
        fast_d       = fast_q;
        slow_0_d     = slow_0_q;
        slow_1_d     = slow_1_q;
        speed_d      = speed_q;
        end_addr_d   = end_addr_q;
        enter_play   = 1'b0;

        case (state_q)
            S_INIT: begin
                // Fire the codec init once, then wait for it; a done level
                // seen before our own strobe is not trusted.
                if (!init_sent_q) begin
                    i2c_start_d = 1'b1;
                    init_sent_d = 1'b1;
                end else if (i_init_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (win_0) begin
                    state_d     = S_REC;
                    rec_start_d = 1'b1;
                end else if (win_1 && (end_addr_q != '0)) begin
                    state_d      = S_PLAY;
                    play_start_d = 1'b1;
                    enter_play   = 1'b1;
                end
            end
            S_REC: begin
                // Hitting the top of SRAM stops the take regardless of keys.
                if (win_2 || (i_rec_addr == MAX_ADDR)) begin
                    state_d    = S_IDLE;
                    rec_stop_d = 1'b1;
                    end_addr_d = i_rec_addr;
                end else if (win_0) begin
                    state_d     = S_REC_PAUSE;
                    rec_pause_d = 1'b1;
                end
            end
            S_REC_PAUSE: begin
                if (win_2) begin
                    state_d    = S_IDLE;
                    rec_stop_d = 1'b1;
                    end_addr_d = i_rec_addr;
                end else if (win_0) begin
                    state_d     = S_REC;
                    rec_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                // Running past the recorded data ends playback before any key.
                if (win_2 || (i_play_addr >= end_addr_q)) begin
                    state_d     = S_IDLE;
                    play_stop_d = 1'b1;
                end else if (win_1) begin
                    state_d      = S_PLAY_PAUSE;
                    play_pause_d = 1'b1;
                end
            end
            S_PLAY_PAUSE: begin
                if (win_2) begin
                    state_d     = S_IDLE;
                    play_stop_d = 1'b1;
                end else if (win_1) begin
                    state_d      = S_PLAY;
                    play_start_d = 1'b1;
                    enter_play   = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Switches are sampled only on entry to playback, so fiddling with
        // them mid-play does not disturb the running stream.
        if (enter_play) begin
            speed_d  = i_speed_sw[SPD_W-1:0];
            fast_d   = 1'b0;
            slow_0_d = 1'b0;
            slow_1_d = 1'b0;
            if (i_speed_sw[SPD_W-1:0] != '0) begin
                if (i_speed_sw[SPD_W])  fast_d   = 1'b1;
                else if (i_interp_sw)   slow_1_d = 1'b1;
                else                    slow_0_d = 1'b1;
            end
        end

        if (state_d == S_IDLE) begin
            fast_d   = 1'b0;
            slow_0_d = 1'b0;
            slow_1_d = 1'b0;
        end

        sel_d = (state_d == S_REC) || (state_d == S_REC_PAUSE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_INIT;
            key_prev_q   <= '0;
            init_sent_q  <= 1'b0;
            i2c_start_q  <= 1'b0;
            rec_start_q  <= 1'b0;
            rec_pause_q  <= 1'b0;
            rec_stop_q   <= 1'b0;
            play_start_q <= 1'b0;
            play_pause_q <= 1'b0;
            play_stop_q  <= 1'b0;
            fast_q       <= 1'b0;
            slow_0_q     <= 1'b0;
            slow_1_q     <= 1'b0;
            speed_q      <= '0;
            sel_q        <= 1'b0;
            end_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_prev_q   <= key_prev_d;
            init_sent_q  <= init_sent_d;
            i2c_start_q  <= i2c_start_d;
            rec_start_q  <= rec_start_d;
            rec_pause_q  <= rec_pause_d;
            rec_stop_q   <= rec_stop_d;
            play_start_q <= play_start_d;
            play_pause_q <= play_pause_d;
            play_stop_q  <= play_stop_d;
            fast_q       <= fast_d;
            slow_0_q     <= slow_0_d;
            slow_1_q     <= slow_1_d;
            speed_q      <= speed_d;
            sel_q        <= sel_d;
            end_addr_q   <= end_addr_d;
        end
    end

    assign o_i2c_start    = i2c_start_q;
    assign o_rec_start    = rec_start_q;
    assign o_rec_pause    = rec_pause_q;
    assign o_rec_stop     = rec_stop_q;
    assign o_play_start   = play_start_q;
    assign o_play_pause   = play_pause_q;
    assign o_play_stop    = play_stop_q;
    assign o_fast         = fast_q;
    assign o_slow_0       = slow_0_q;
    assign o_slow_1       = slow_1_q;
    assign o_speed        = speed_q;
    assign o_sram_rec_sel = sel_q;
    assign o_rec_end_addr = end_addr_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aud_mode_ctrl
//   Directed bench for aud_mode_ctrl: walks init, record, pause, auto-stop,
//   playback with speed latching, end-of-data stop, key priority and a
//   mid-record reset, checking hand-computed values after each step.
// ----------------------------------------------------------------------------
module tb_aud_mode_ctrl;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned SPD_W  = 3;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_key_0, i_key_1, i_key_2;
    logic [SPD_W:0]    i_speed_sw;
    logic              i_interp_sw;
    logic              i_init_done;
    logic [ADDR_W-1:0] i_rec_addr;
    logic [ADDR_W-1:0] i_play_addr;
    logic              o_i2c_start;
    logic              o_rec_start, o_rec_pause, o_rec_stop;
    logic              o_play_start, o_play_pause, o_play_stop;
    logic              o_fast, o_slow_0, o_slow_1;
    logic [SPD_W-1:0]  o_speed;
    logic              o_sram_rec_sel;
    logic [ADDR_W-1:0] o_rec_end_addr;
    logic [2:0]        o_state;

    int errors = 0;
    int checks = 0;

    aud_mode_ctrl #(.ADDR_W(ADDR_W), .SPD_W(SPD_W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key_0        (i_key_0),
        .i_key_1        (i_key_1),
        .i_key_2        (i_key_2),
        .i_speed_sw     (i_speed_sw),
        .i_interp_sw    (i_interp_sw),
        .i_init_done    (i_init_done),
        .i_rec_addr     (i_rec_addr),
        .i_play_addr    (i_play_addr),
        .o_i2c_start    (o_i2c_start),
        .o_rec_start    (o_rec_start),
        .o_rec_pause    (o_rec_pause),
        .o_rec_stop     (o_rec_stop),
        .o_play_start   (o_play_start),
        .o_play_pause   (o_play_pause),
        .o_play_stop    (o_play_stop),
        .o_fast         (o_fast),
        .o_slow_0       (o_slow_0),
        .o_slow_1       (o_slow_1),
        .o_speed        (o_speed),
        .o_sram_rec_sel (o_sram_rec_sel),
        .o_rec_end_addr (o_rec_end_addr),
        .o_state        (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Hold the given keys high across exactly one edge, then release.
    task automatic press(input logic [2:0] k);
        {i_key_2, i_key_1, i_key_0} = k;
        tick();
        {i_key_2, i_key_1, i_key_0} = 3'b000;
    endtask

    // All six strobes packed {rec_start,rec_pause,rec_stop,play_start,play_pause,play_stop}.
    function automatic logic [5:0] strobes();
        return {o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause, o_play_stop};
    endfunction

    function automatic logic [2:0] modes();
        return {o_fast, o_slow_1, o_slow_0};
    endfunction

    initial begin
        i_rst = 1'b1;
        {i_key_2, i_key_1, i_key_0} = 3'b000;
        i_speed_sw  = '0;
        i_interp_sw = 1'b0;
        i_init_done = 1'b0;
        i_rec_addr  = '0;
        i_play_addr = '0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_state",   o_state, 3'd0);
        check("rst_i2c",     o_i2c_start, 1'b0);
        check("rst_strobes", strobes(), 6'b0);
        check("rst_modes",   modes(), 3'b0);
        check("rst_speed",   o_speed, 3'd0);
        check("rst_sel",     o_sram_rec_sel, 1'b0);
        check("rst_end",     o_rec_end_addr, 20'h0);

        // ---- init: strobe at cycle 1, keys ignored, IDLE at cycle 11 ----
        i_rst = 1'b0;
        tick();                                    // edge 1
        check("init_i2c_pulse", o_i2c_start, 1'b1);
        check("init_state",     o_state, 3'd0);
        press(3'b001);                             // edge 2
        check("init_i2c_once",  o_i2c_start, 1'b0);
        check("init_key_ign",   strobes(), 6'b0);
        for (int i = 3; i <= 10; i++) tick();      // edges 3..10
        check("init_wait",      o_state, 3'd0);
        i_init_done = 1'b1;
        tick();                                    // edge 11
        check("init_idle",      o_state, 3'd1);
        check("init_i2c_quiet", o_i2c_start, 1'b0);

        // ---- IDLE: play refused with no recording; record starts ----
        press(3'b010);
        check("idle_play_ign_st",  o_state, 3'd1);
        check("idle_play_ign_stb", strobes(), 6'b0);
        tick();
        press(3'b001);
        check("rec_start_stb", strobes(), 6'b100000);
        check("rec_state",     o_state, 3'd2);
        check("rec_sel",       o_sram_rec_sel, 1'b1);
        tick();
        check("rec_start_1cyc", strobes(), 6'b0);

        // ---- REC: manual stop captures end address ----
        i_rec_addr = 20'h00123;
        press(3'b100);
        check("rec_stop_stb", strobes(), 6'b001000);
        check("rec_stop_st",  o_state, 3'd1);
        check("rec_stop_end", o_rec_end_addr, 20'h00123);
        check("rec_stop_sel", o_sram_rec_sel, 1'b0);
        tick();
        check("rec_stop_1cyc", strobes(), 6'b0);

        // ---- new take: end addr held, pause, resume, auto-stop over key ----
        i_rec_addr = 20'h00000;
        press(3'b001);
        check("rec2_state",    o_state, 3'd2);
        check("rec2_end_held", o_rec_end_addr, 20'h00123);
        tick();
        press(3'b001);
        check("rec_pause_stb", strobes(), 6'b010000);
        check("rec_pause_st",  o_state, 3'd3);
        check("rec_pause_sel", o_sram_rec_sel, 1'b1);
        tick();
        press(3'b001);
        check("rec_resume_stb", strobes(), 6'b100000);
        check("rec_resume_st",  o_state, 3'd2);
        tick();
        i_rec_addr = 20'hFFFFF;
        press(3'b001);
        check("auto_stop_stb", strobes(), 6'b001000);
        check("auto_stop_st",  o_state, 3'd1);
        check("auto_stop_end", o_rec_end_addr, 20'hFFFFF);
        tick();

        // ---- short take ending at 0x200 for the playback tests ----
        press(3'b001);
        i_rec_addr = 20'h00200;
        tick();
        press(3'b100);
        check("rec3_end", o_rec_end_addr, 20'h00200);
        tick();

        // ---- play fast 4x; switch change mid-play has no effect ----
        i_speed_sw  = 4'b1011;
        i_play_addr = 20'h00000;
        press(3'b010);
        check("play_start_stb", strobes(), 6'b000100);
        check("play_state",     o_state, 3'd4);
        check("play_fast",      modes(), 3'b100);
        check("play_speed",     o_speed, 3'd3);
        check("play_sel",       o_sram_rec_sel, 1'b0);
        i_speed_sw = 4'b0000;
        tick();
        check("play_speed_held", o_speed, 3'd3);
        check("play_modes_held", modes(), 3'b100);
        press(3'b010);
        check("play_pause_stb", strobes(), 6'b000010);
        check("play_pause_st",  o_state, 3'd5);
        check("play_pause_mod", modes(), 3'b100);
        tick();
        press(3'b100);
        check("pp_stop_stb", strobes(), 6'b000001);
        check("pp_stop_st",  o_state, 3'd1);
        check("pp_stop_mod", modes(), 3'b000);
        tick();

        // ---- slow 2x linear, then play runs into end of data ----
        i_speed_sw  = 4'b0001;
        i_interp_sw = 1'b1;
        press(3'b010);
        check("slow1_modes", modes(), 3'b010);
        check("slow1_speed", o_speed, 3'd1);
        i_play_addr = 20'h001FF;
        tick();
        check("eod_not_yet", o_state, 3'd4);
        i_play_addr = 20'h00200;
        tick();
        check("eod_stop_stb", strobes(), 6'b000001);
        check("eod_state",    o_state, 3'd1);
        check("eod_modes",    modes(), 3'b000);
        tick();
        check("eod_1cyc",     strobes(), 6'b0);

        // ---- factor 0 gives 1x (all levels 0); stop beats pause ----
        i_play_addr = 20'h00000;
        i_speed_sw  = 4'b1000;
        press(3'b010);
        check("x1_state", o_state, 3'd4);
        check("x1_modes", modes(), 3'b000);
        tick();
        press(3'b110);
        check("prio_stb",   strobes(), 6'b000001);
        check("prio_state", o_state, 3'd1);
        tick();

        // ---- slow constant, re-latch on resume from pause ----
        i_speed_sw  = 4'b0010;
        i_interp_sw = 1'b0;
        press(3'b010);
        check("slow0_modes", modes(), 3'b001);
        tick();
        press(3'b010);
        i_speed_sw = 4'b1101;
        tick();
        press(3'b010);
        check("resume_stb",   strobes(), 6'b000100);
        check("resume_modes", modes(), 3'b100);
        check("resume_speed", o_speed, 3'd5);
        tick();
        press(3'b100);
        tick();

        // ---- reset while recording: back to INIT, no stop strobes ----
        i_rec_addr = 20'h00010;
        press(3'b001);
        check("prerst_state", o_state, 3'd2);
        i_rst = 1'b1;
        #1;
        check("arst_state",   o_state, 3'd0);
        check("arst_strobes", strobes(), 6'b0);
        check("arst_sel",     o_sram_rec_sel, 1'b0);
        check("arst_end",     o_rec_end_addr, 20'h0);
        tick();
        check("arst_hold",    strobes(), 6'b0);
        i_rst = 1'b0;
        tick();
        check("rerun_i2c",    o_i2c_start, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
